// File: rtl/popcount_pkg.sv
// Shared definitions for the sequential population counter.
//   state_t : FSM encoding (IDLE, RUN, DONE)
//   cw()    : bits needed to hold a count of 0..width without wrap
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cw(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational ones count of an N-bit slice.
//   i_bits : slice to count
//   o_ones : number of set bits in i_bits, cw(N) bits wide
module popcount_chunk
    import popcount_pkg::*;
#(
    parameter  int N  = 4,
    localparam int OW = cw(N)
) (
    input  logic [N-1:0]  i_bits,
    output logic [OW-1:0] o_ones
);

    logic [OW-1:0] w_sum;

    // Ripple sum of individual bits; N is small so the chain stays short.
    always_comb begin
        w_sum = {OW{1'b0}};
        for (int i = 0; i < N; i++) begin
            w_sum = w_sum + OW'(i_bits[i]);
        end
    end

    assign o_ones = w_sum;

endmodule

// File: rtl/popcount_seq.sv
// Multi-cycle ones/zeros counter. A WIDTH-bit word is captured on start and
// counted BITS_PER_CYCLE bits per clock; the result is presented with a
// one-cycle done pulse and held until the next result.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   start  : request, sampled in IDLE and DONE only
//   mode   : 0 = count ones, 1 = count zeros (captured with start)
//   din    : operand (captured with start)
//   busy   : high while counting (RUN state)
//   done   : one-cycle pulse when count is valid
//   count  : last result, held between done pulses
//   parity : count[0]
module popcount_seq
    import popcount_pkg::*;
#(
    parameter  int WIDTH          = 16,
    parameter  int BITS_PER_CYCLE = 4,
    localparam int CW             = cw(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic             parity
);

    localparam int NCHUNK = WIDTH / BITS_PER_CYCLE;
    localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int OW     = cw(BITS_PER_CYCLE);
    localparam logic [CNTW-1:0] LAST_CHUNK = CNTW'(NCHUNK - 1);

    // Reject configurations that cannot be counted in whole chunks.
    generate
        if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0 || BITS_PER_CYCLE < 1) begin : g_bad_param
            $error("popcount_seq: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_acc;
    logic [CNTW-1:0]  r_chunk;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;

    logic [OW-1:0]    w_chunk;
    logic [CW-1:0]    w_sum;

    popcount_chunk #(
        .N (BITS_PER_CYCLE)
    ) u_chunk (
        .i_bits (r_shift[BITS_PER_CYCLE-1:0]),
        .o_ones (w_chunk)
    );

    // Running total including the chunk being processed this cycle.
    assign w_sum = r_acc + CW'(w_chunk);

    // FSM, datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_shift <= {WIDTH{1'b0}};
            r_acc   <= {CW{1'b0}};
            r_chunk <= {CNTW{1'b0}};
            r_count <= {CW{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    // DONE accepts a new request exactly like IDLE so
                    // back-to-back requests lose no cycle.
                    if (start) begin
                        r_shift <= mode ? ~din : din;
                        r_acc   <= {CW{1'b0}};
                        r_chunk <= {CNTW{1'b0}};
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    r_acc   <= w_sum;
                    r_shift <= r_shift >> BITS_PER_CYCLE;
                    r_chunk <= r_chunk + CNTW'(1);
                    if (r_chunk == LAST_CHUNK) begin
                        r_count <= w_sum;
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign count  = r_count;
    assign parity = r_count[0];

endmodule

// File: tb/tb_popcount_seq.sv
module tb_popcount_seq;

    logic        clk;
    logic        rst_n;

    // 16-bit, 4 bits per cycle instance
    logic        a_start;
    logic        a_mode;
    logic [15:0] a_din;
    logic        a_busy;
    logic        a_done;
    logic [4:0]  a_count;
    logic        a_parity;

    // 6-bit, single-chunk instance
    logic        b_start;
    logic        b_mode;
    logic [5:0]  b_din;
    logic        b_busy;
    logic        b_done;
    logic [2:0]  b_count;
    logic        b_parity;

    int n_checks;
    int n_pass;

    popcount_seq #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (a_start),
        .mode   (a_mode),
        .din    (a_din),
        .busy   (a_busy),
        .done   (a_done),
        .count  (a_count),
        .parity (a_parity)
    );

    popcount_seq #(.WIDTH(6), .BITS_PER_CYCLE(6)) u_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (b_start),
        .mode   (b_mode),
        .din    (b_din),
        .busy   (b_busy),
        .done   (b_done),
        .count  (b_count),
        .parity (b_parity)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the 16-bit instance and check the exact timing:
    // busy for 4 observations (count holding prev), then done with exp.
    task automatic run_a(input logic [15:0] d, input logic m,
                         input logic [4:0] exp, input logic [4:0] prev,
                         input string name);
        a_din   = d;
        a_mode  = m;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (a_busy !== 1'b1 || a_done !== 1'b0 || a_count !== prev)
                $display("FAIL %s_run k=%0d: busy=%b done=%b count=%0d, want busy=1 done=0 count=%0d",
                         name, k, a_busy, a_done, a_count, prev);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (a_done !== 1'b1 || a_busy !== 1'b0 || a_count !== exp || a_parity !== exp[0])
            $display("FAIL %s_done: done=%b busy=%b count=%0d parity=%b, want done=1 busy=0 count=%0d parity=%b",
                     name, a_done, a_busy, a_count, a_parity, exp, exp[0]);
        else n_pass++;
        tick();
        n_checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b0 || a_count !== exp)
            $display("FAIL %s_idle: done=%b busy=%b count=%0d, want done=0 busy=0 count=%0d",
                     name, a_done, a_busy, a_count, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        a_start = 1'b0; a_mode = 1'b0; a_din = 16'h0000;
        b_start = 1'b0; b_mode = 1'b0; b_din = 6'h00;
        #22;
        n_checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_count !== 5'd0 || a_parity !== 1'b0)
            $display("FAIL reset_a: busy=%b done=%b count=%0d parity=%b, want all 0",
                     a_busy, a_done, a_count, a_parity);
        else n_pass++;
        n_checks++;
        if (b_busy !== 1'b0 || b_done !== 1'b0 || b_count !== 3'd0 || b_parity !== 1'b0)
            $display("FAIL reset_b: busy=%b done=%b count=%0d parity=%b, want all 0",
                     b_busy, b_done, b_count, b_parity);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0)
            $display("FAIL idle_no_start: busy=%b done=%b, want 0 0", a_busy, a_done);
        else n_pass++;
    endtask

    task automatic test_basic();
        run_a(16'h00F0, 1'b0, 5'd4, 5'd0, "basic_00F0");
    endtask

    task automatic test_full_empty();
        run_a(16'hFFFF, 1'b0, 5'd16, 5'd4, "all_ones");
        run_a(16'h0000, 1'b0, 5'd0, 5'd16, "all_zero");
    endtask

    task automatic test_mode();
        run_a(16'h0014, 1'b1, 5'd14, 5'd0, "zeros_0014");
        run_a(16'h0001, 1'b0, 5'd1, 5'd14, "ones_0001");
    endtask

    task automatic test_start_in_run();
        bit extra_done;
        a_din   = 16'h0003;
        a_mode  = 1'b0;
        a_start = 1'b1;
        tick();
        a_din  = 16'hFFFF;
        a_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (a_busy !== 1'b1 || a_count !== 5'd1)
                $display("FAIL start_in_run k=%0d: busy=%b count=%0d, want busy=1 count=1",
                         k, a_busy, a_count);
            else n_pass++;
            if (k == 3) a_start = 1'b0;
            tick();
        end
        n_checks++;
        if (a_done !== 1'b1 || a_count !== 5'd2 || a_parity !== 1'b0)
            $display("FAIL start_in_run_done: done=%b count=%0d parity=%b, want 1 2 0",
                     a_done, a_count, a_parity);
        else n_pass++;
        extra_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (a_done !== 1'b0 || a_busy !== 1'b0) extra_done = 1'b1;
        end
        n_checks++;
        if (extra_done !== 1'b0 || a_count !== 5'd2)
            $display("FAIL no_second_done: extra activity=%b count=%0d, want 0 2",
                     extra_done, a_count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int c;
        a_din   = 16'h000F;
        a_mode  = 1'b0;
        a_start = 1'b1;
        c = 0;
        do begin tick(); c++; end while (a_done !== 1'b1 && c < 12);
        n_checks++;
        if (c !== 5 || a_count !== 5'd4)
            $display("FAIL b2b_first: latency=%0d count=%0d, want 5 4", c, a_count);
        else n_pass++;
        a_din = 16'h00FF;
        c = 0;
        do begin
            tick();
            c++;
            if (c == 1) begin
                n_checks++;
                if (a_busy !== 1'b1 || a_done !== 1'b0)
                    $display("FAIL b2b_recapture: busy=%b done=%b, want 1 0", a_busy, a_done);
                else n_pass++;
                a_start = 1'b0;
            end
        end while (a_done !== 1'b1 && c < 12);
        n_checks++;
        if (c !== 5 || a_count !== 5'd8 || a_parity !== 1'b0)
            $display("FAIL b2b_second: spacing=%0d count=%0d parity=%b, want 5 8 0",
                     c, a_count, a_parity);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_run();
        a_din   = 16'hFFFF;
        a_mode  = 1'b0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0 || a_count !== 5'd0 || a_parity !== 1'b0)
            $display("FAIL reset_mid_run: busy=%b done=%b count=%0d parity=%b, want all 0",
                     a_busy, a_done, a_count, a_parity);
        else n_pass++;
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0)
            $display("FAIL after_reset_idle: busy=%b done=%b, want 0 0", a_busy, a_done);
        else n_pass++;
        run_a(16'h00F0, 1'b0, 5'd4, 5'd0, "restart");
    endtask

    function automatic int ones6(input logic [5:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 6; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic test_w6();
        logic [5:0] v;
        logic [2:0] exp;
        int         bad_lat;
        int         bad_val;
        bad_lat = 0;
        bad_val = 0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 64; i++) begin
                v       = 6'(i);
                exp     = (m == 0) ? 3'(ones6(v)) : 3'(6 - ones6(v));
                b_din   = v;
                b_mode  = m[0];
                b_start = 1'b1;
                tick();
                b_start = 1'b0;
                if (b_busy !== 1'b1 || b_done !== 1'b0) bad_lat++;
                tick();
                if (b_done !== 1'b1 || b_busy !== 1'b0) bad_lat++;
                if (b_count !== exp || b_parity !== exp[0]) begin
                    bad_val++;
                    if (bad_val <= 4)
                        $display("FAIL w6_value m=%0d din=%h: count=%0d parity=%b, want %0d %b",
                                 m, v, b_count, b_parity, exp, exp[0]);
                end
                tick();
                if (b_done !== 1'b0) bad_lat++;
            end
            n_checks++;
            if (bad_lat !== 0)
                $display("FAIL w6_timing m=%0d: %0d timing errors, want 0", m, bad_lat);
            else n_pass++;
            n_checks++;
            if (bad_val !== 0)
                $display("FAIL w6_values m=%0d: %0d wrong counts, want 0", m, bad_val);
            else n_pass++;
            bad_lat = 0;
            bad_val = 0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic();
        test_full_empty();
        test_mode();
        test_start_in_run();
        test_back_to_back();
        test_reset_mid_run();
        test_w6();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/popcount_seq.md
# popcount_seq

Parametrised, multi-cycle ones/zeros counter, the sequential successor to the team's fixed 6-bit combinational ones counter. It captures a WIDTH-bit word on a start strobe and processes BITS_PER_CYCLE bits per clock. It then presents the population count, selectable as ones or zeros, with a one-cycle done pulse. It sits between a register-file read port and the status/ALU logic, trading latency for area at large widths.

## Interface
- WIDTH, 16: input word width; ≥ 2.
- BITS_PER_CYCLE, 4: bits counted per clock; must divide WIDTH exactly (elaboration error otherwise).
- Derived: NCHUNK = WIDTH/BITS_PER_CYCLE; CW = $clog2(WIDTH+1).

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only when not busy.
- mode  input  1  0 = count ones, 1 = count zeros; captured with start.
- din  input  WIDTH  operand; captured with start.
- busy  output  1  high while a count is in progress.
- done  output  1  one-cycle pulse when count is valid.
- count  output  CW  last result; held until the next done.
- parity  output  1  count[0], i.e. odd parity of the selected bit value.

One clock and one reset. Reset is asynchronous and active-low.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with start=1: capture din into the shift register.
  - If mode=1, the register holds ~din.
  - Clear the accumulator and the chunk counter.
  - Go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, every cycle:
  - accumulator += number of ones in the low BITS_PER_CYCLE bits of the shift register.
  - Shift the register right by BITS_PER_CYCLE.
  - Increment the chunk counter.
- RUN, on the cycle processing chunk NCHUNK-1: load count with the final sum and go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 here is accepted: it captures exactly as from IDLE and goes to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- start while in RUN is ignored; din and mode changes during RUN have no effect.
- Width rule: the accumulator is CW bits. The maximum value WIDTH must be representable without wrap (e.g. 16 needs 5 bits).
- Chunk adder output width is $clog2(BITS_PER_CYCLE+1), zero-extended to CW before the add.
- parity is combinationally count[0].

## Timing
- Reset values:
  - state=IDLE, busy=0, done=0, count=0, parity=0.
  - Shift register, accumulator and chunk counter = 0.
- busy = (state==RUN). It is 0 in IDLE and in DONE.
- Latency: start sampled at edge E makes done high in the cycle after edge E+NCHUNK, i.e. NCHUNK+1 cycles after the start cycle. For 16/4 that is 5 cycles.
- Throughput with start held high: one result every NCHUNK+1 cycles.
- count updates only at the edge entering DONE. It stays stable through RUN, showing the previous result, and through IDLE.
- Reset mid-RUN aborts immediately: no done pulse; count returns to 0.
- Corner case BITS_PER_CYCLE = WIDTH: NCHUNK=1, so there is a single RUN cycle and done appears 2 cycles after start.

## Structure
- Package popcount_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function cw(width) returning $clog2(width+1).
- Sub-module popcount_chunk (parameter N): purely combinational ones count of an N-bit slice. It is instantiated once in the datapath.
- Top level contains the FSM, the shift register, the chunk counter and the accumulator/result registers.

## Test plan
- WIDTH=16, BPC=4, din=16'h00F0, mode=0, start pulse → busy for 4 cycles, done 5 cycles after start, count=4, parity=0.
- din=16'hFFFF, mode=0 → count=16 (5'b10000, no wrap), parity=0. Then din=16'h0000 → count=0.
- din=16'h0014, mode=1 → count=14, parity=0. din=16'h0001, mode=0 → count=1, parity=1.
- start asserted during RUN with din=16'hFFFF while the original din=16'h0003 → count=2, no second done.
- start held high, din=16'h000F then 16'h00FF presented in the DONE cycle → done pulses 5 cycles apart, count=4 then 8.
- rst_n low during the 3rd RUN cycle → async clear: busy=0, done=0, count=0 at once. A restart after reset completes normally.
- Repeat the first and third scenarios with WIDTH=6, BPC=6 → single RUN cycle; count matches the combinational reference for all 64 inputs.
